sprite_angle_ctrl: RTL and testbench

Per-sprite rotation controller upstream of the sprite renderer. It holds an 8-bit heading angle, steps it once per frame from player rotate keys, and converts it to the signed Q1.16 sin/cos pair that the renderer's rotation datapath consumes. It uses one shared 65-entry quarter-wave table over a 3-cycle sequenced lookup. Outputs change only right after frame_start, so a sprite never tears mid-frame.

---
 rtl/sprite_angle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sprite_angle_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_angle_ctrl.sv
// Per-sprite heading register with frame-synchronous rotate/load and a
// sequenced quarter-wave ROM lookup producing signed Q1.16 sin/cos.
module sprite_angle_ctrl #(
   parameter int STEP      = 2,
   parameter int FRAME_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        rot_left,
   input  logic        rot_right,
   input  logic        load_angle,
   input  logic [7:0]  load_value,
   output logic [7:0]  angle,
   output logic [17:0] sin_val,
   output logic [17:0] cos_val,
   output logic        upd_done
);

   localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DW-1:0] DIV_RELOAD = DW'(FRAME_DIV - 1);
   localparam logic [7:0]    STEP_A     = 8'(STEP);
   localparam longint        PI_Q30     = 64'sd3373259426;
   localparam longint        MASK30     = 64'sh3FFF_FFFF;

   typedef enum logic [1:0] {IDLE, ADDR_SIN, ADDR_COS, CAPTURE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    angle_q, angle_d;
   logic [7:0]    load_q, load_d;
   logic          pend_q, pend_d;
   logic [DW-1:0] div_q, div_d;
   logic          neg_q, neg_d;
   logic [17:0]   sin_tmp_q, sin_tmp_d;
   logic [17:0]   sin_q, sin_d;
   logic [17:0]   cos_q, cos_d;
   logic          upd_q, upd_d;

   logic [16:0]   rom [0:64];
   logic [16:0]   rom_q;
   logic [6:0]    rom_addr;
   logic [7:0]    cos_angle;
   logic [6:0]    sin_idx, cos_idx;

   // round(65536*sin(pi*k/128)) by Taylor series in Q60 fixed point; evaluated
   // only on constant arguments so the table folds to ROM contents.
   function automatic logic [16:0] qsin(input int k);
      longint x30, x2, term, sum, hi, lo;
      x30  = (longint'(k) * PI_Q30) >>> 7;
      x2   = (x30 * x30) >>> 30;
      term = (longint'(k) * PI_Q30) <<< 23;
      sum  = term;
      for (int n = 1; n <= 12; n++) begin
         hi   = term >>> 30;
         lo   = term & MASK30;
         term = (hi * x2 + ((lo * x2) >>> 30)) / longint'(4 * n * n + 2 * n);
         if ((n % 2) == 1) sum = sum - term;
         else              sum = sum + term;
      end
      return 17'((sum + 64'sd8796093022208) >>> 44);
   endfunction

   function automatic logic [6:0] fold_idx(input logic [7:0] a);
      return a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
   endfunction

   function automatic logic [17:0] apply_sign(input logic neg, input logic [16:0] mag);
      return neg ? (18'd0 - {1'b0, mag}) : {1'b0, mag};
   endfunction

   for (genvar gi = 0; gi <= 64; gi++) begin : g_rom
      assign rom[gi] = qsin(gi);
   end

   always_ff @(posedge clk) begin
      rom_q <= rom[rom_addr];
   end

   assign cos_angle = angle_q + 8'd64;
   assign sin_idx   = fold_idx(angle_q);
   assign cos_idx   = fold_idx(cos_angle);

   always_comb begin
      state_d   = state_q;
      angle_d   = angle_q;
      load_d    = load_q;
      pend_d    = pend_q;
      div_d     = div_q;
      neg_d     = neg_q;
      sin_tmp_d = sin_tmp_q;
      sin_d     = sin_q;
      cos_d     = cos_q;
      upd_d     = 1'b0;
      rom_addr  = sin_idx;

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = ADDR_SIN;
               if (pend_q) begin
                  angle_d = load_q;
                  pend_d  = 1'b0;
                  div_d   = '0;
               end else if (rot_left ^ rot_right) begin
                  if (div_q == '0) begin
                     angle_d = rot_left ? (angle_q + STEP_A) : (angle_q - STEP_A);
                     div_d   = DIV_RELOAD;
                  end else begin
                     div_d = div_q - DW'(1);
                  end
               end else begin
                  div_d = '0;
               end
            end
         end
         ADDR_SIN: begin
            rom_addr = sin_idx;
            neg_d    = angle_q[7];
            state_d  = ADDR_COS;
         end
         ADDR_COS: begin
            rom_addr  = cos_idx;
            sin_tmp_d = apply_sign(neg_q, rom_q);
            neg_d     = cos_angle[7];
            state_d   = CAPTURE;
         end
         CAPTURE: begin
            sin_d   = sin_tmp_q;
            cos_d   = apply_sign(neg_q, rom_q);
            upd_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A load arriving with the consuming frame_start stays pending for the next frame.
      if (load_angle) begin
         load_d = load_value;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         angle_q   <= 8'd0;
         load_q    <= 8'd0;
         pend_q    <= 1'b0;
         div_q     <= '0;
         neg_q     <= 1'b0;
         sin_tmp_q <= 18'd0;
         sin_q     <= 18'd0;
         cos_q     <= 18'd65536;
         upd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         angle_q   <= angle_d;
         load_q    <= load_d;
         pend_q    <= pend_d;
         div_q     <= div_d;
         neg_q     <= neg_d;
         sin_tmp_q <= sin_tmp_d;
         sin_q     <= sin_d;
         cos_q     <= cos_d;
         upd_q     <= upd_d;
      end
   end

   assign angle    = angle_q;
   assign sin_val  = sin_q;
   assign cos_val  = cos_q;
   assign upd_done = upd_q;

endmodule

// File: tb/tb_sprite_angle_ctrl.sv
// Bench for sprite_angle_ctrl: directed vectors and corner sequences plus
// randomized stimulus checked every cycle against a frame-level reference model.
module tb_sprite_angle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        rot_left = 1'b0;
   logic        rot_right = 1'b0;
   logic        load_angle = 1'b0;
   logic [7:0]  load_value = 8'd0;

   logic [7:0]  angle_a, angle_b;
   logic [17:0] sin_a, cos_a, sin_b, cos_b;
   logic        upd_a, upd_b;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   sprite_angle_ctrl #(.STEP(2), .FRAME_DIV(1)) dut_a (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .rot_left(rot_left), .rot_right(rot_right),
      .load_angle(load_angle), .load_value(load_value),
      .angle(angle_a), .sin_val(sin_a), .cos_val(cos_a), .upd_done(upd_a)
   );

   sprite_angle_ctrl #(.STEP(2), .FRAME_DIV(3)) dut_b (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .rot_left(rot_left), .rot_right(rot_right),
      .load_angle(load_angle), .load_value(load_value),
      .angle(angle_b), .sin_val(sin_b), .cos_val(cos_b), .upd_done(upd_b)
   );

   // Reference: frame-level behaviour; busy counts the clocks until results appear.
   typedef struct {
      int angle;
      int pend;
      int stored;
      int dcnt;
      int busy;
      int sinv;
      int cosv;
      int upd;
   } mstate_t;

   mstate_t ma, mb;

   function automatic int ref_sin(input int a);
      real r, m;
      r = $sin(6.283185307179586 * a / 256.0);
      m = $floor(65536.0 * ((r < 0.0) ? -r : r) + 0.5);
      return (r < 0.0) ? -$rtoi(m) : $rtoi(m);
   endfunction

   function automatic mstate_t mreset();
      mstate_t s;
      s.angle = 0; s.pend = 0; s.stored = 0; s.dcnt = 0;
      s.busy = 0; s.sinv = 0; s.cosv = 65536; s.upd = 0;
      return s;
   endfunction

   function automatic mstate_t mstep(input mstate_t s, input logic fs, input logic rl,
                                     input logic rr, input logic ld, input logic [7:0] lv,
                                     input int stp, input int fdiv);
      mstate_t n;
      n = s;
      n.upd = 0;
      if (s.busy != 0) begin
         n.busy = s.busy - 1;
         if (n.busy == 0) begin
            n.sinv = ref_sin(s.angle);
            n.cosv = ref_sin((s.angle + 64) % 256);
            n.upd  = 1;
         end
      end else if (fs) begin
         if (s.pend != 0) begin
            n.angle = s.stored;
            n.pend  = 0;
            n.dcnt  = 0;
         end else if (rl != rr) begin
            if (s.dcnt == 0) begin
               n.angle = (s.angle + (rl ? stp : 256 - stp)) % 256;
               n.dcnt  = fdiv - 1;
            end else begin
               n.dcnt = s.dcnt - 1;
            end
         end else begin
            n.dcnt = 0;
         end
         n.busy = 3;
      end
      if (ld) begin
         n.stored = int'(lv);
         n.pend   = 1;
      end
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ma <= mreset();
         mb <= mreset();
      end else begin
         ma <= mstep(ma, frame_start, rot_left, rot_right, load_angle, load_value, 2, 1);
         mb <= mstep(mb, frame_start, rot_left, rot_right, load_angle, load_value, 2, 3);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("a_angle", int'(angle_a), ma.angle);
         check("a_sin", int'($signed(sin_a)), ma.sinv);
         check("a_cos", int'($signed(cos_a)), ma.cosv);
         check("a_upd", int'(upd_a), ma.upd);
         check("b_angle", int'(angle_b), mb.angle);
         check("b_sin", int'($signed(sin_b)), mb.sinv);
         check("b_cos", int'($signed(cos_b)), mb.cosv);
         check("b_upd", int'(upd_b), mb.upd);
         if (upd_a)
            $display("update a: angle=%0d sin=%0d cos=%0d", angle_a, $signed(sin_a), $signed(cos_a));
      end
   end

   task automatic do_load(input logic [7:0] v);
      load_angle = 1'b1;
      load_value = v;
      @(negedge clk);
      load_angle = 1'b0;
   endtask

   // Pulse frame_start with the given keys, then wait (bounded) for dut_a's update.
   task automatic do_frame(input logic rl, input logic rr);
      bit got;
      got = 1'b0;
      rot_left    = rl;
      rot_right   = rr;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (upd_a) got = 1'b1;
      end
      check("upd_timeout", int'(got), 1);
   endtask

   task automatic check_out_a(input string tag, input int ea, input int es, input int ec);
      check({tag, "_angle"}, int'(angle_a), ea);
      check({tag, "_sin"}, int'($signed(sin_a)), es);
      check({tag, "_cos"}, int'($signed(cos_a)), ec);
   endtask

   typedef struct {
      logic [7:0] load;
      int         exp_angle;
      int         exp_sin;
      int         exp_cos;
   } vec_t;

   vec_t vecs [6];
   int   div_exp [7];

   initial begin
      int cnt;
      vecs[0] = '{8'd32,  32,  46341,  46341};
      vecs[1] = '{8'd64,  64,  65536,  0};
      vecs[2] = '{8'd128, 128, 0,      -65536};
      vecs[3] = '{8'd192, 192, -65536, 0};
      vecs[4] = '{8'd16,  16,  25080,  60547};
      vecs[5] = '{8'd2,   2,   3216,   65457};
      div_exp = '{2, 2, 2, 4, 4, 4, 6};

      // Reset state, then one lookup at angle 0
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_out_a("rst", 0, 0, 65536);
      check("rst_upd", int'(upd_a), 0);
      do_frame(1'b0, 1'b0);
      check_out_a("first", 0, 0, 65536);
      @(negedge clk);
      check("upd_one_clock", int'(upd_a), 0);

      // Load table
      for (int v = 0; v < 6; v++) begin
         do_load(vecs[v].load);
         do_frame(1'b0, 1'b0);
         check_out_a($sformatf("vec%0d", v), vecs[v].exp_angle, vecs[v].exp_sin, vecs[v].exp_cos);
         check($sformatf("vec%0d_b_angle", v), int'(angle_b), vecs[v].exp_angle);
      end

      // Wrap both directions
      do_load(8'd0);
      do_frame(1'b0, 1'b0);
      do_frame(1'b0, 1'b1);
      check_out_a("wrap_right", 254, -3216, 65457);
      do_frame(1'b1, 1'b0);
      check_out_a("wrap_left", 0, 0, 65536);

      // Frame divider on dut_b
      do_load(8'd0);
      do_frame(1'b0, 1'b0);
      for (int f = 0; f < 7; f++) begin
         do_frame(1'b1, 1'b0);
         check($sformatf("div_frame%0d", f + 1), int'(angle_b), div_exp[f]);
      end
      do_frame(1'b0, 1'b0);
      check("div_release", int'(angle_b), 6);
      do_frame(1'b1, 1'b0);
      check("div_fresh_press", int'(angle_b), 8);
      do_frame(1'b1, 1'b1);
      check("div_both_keys", int'(angle_b), 8);

      // Last load wins and overrides a held key for one frame
      rot_left = 1'b1;
      do_load(8'd10);
      do_load(8'd16);
      do_frame(1'b1, 1'b0);
      check_out_a("load_last", 16, 25080, 60547);
      do_frame(1'b1, 1'b0);
      check("load_then_step", int'(angle_a), 18);

      // frame_start during ADDR_COS is ignored
      rot_left = 1'b0;
      frame_start = 1'b1;
      cnt = 0;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      frame_start = 1'b1;
      rot_left = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      rot_left = 1'b0;
      if (upd_a) cnt++;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (upd_a) cnt++;
      end
      check("busy_one_update", cnt, 1);
      check("busy_angle", int'(angle_a), 18);

      // Asynchronous reset during ADDR_SIN clears outputs and pending load
      frame_start = 1'b1;
      load_angle  = 1'b1;
      load_value  = 8'd77;
      @(negedge clk);
      frame_start = 1'b0;
      load_angle  = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_out_a("async_rst", 0, 0, 65536);
      check("async_rst_upd", int'(upd_a), 0);
      check("async_rst_b_cos", int'($signed(cos_b)), 65536);
      @(negedge clk);
      reset = 1'b0;
      do_frame(1'b0, 1'b0);
      check_out_a("pend_cleared", 0, 0, 65536);

      // Randomized traffic against the reference model
      for (int c = 0; c < 2500; c++) begin
         frame_start = ($urandom_range(0, 3) == 0);
         load_angle  = ($urandom_range(0, 15) == 0);
         load_value  = 8'($urandom);
         if ($urandom_range(0, 7) == 0) rot_left  = 1'($urandom);
         if ($urandom_range(0, 7) == 0) rot_right = 1'($urandom);
         reset = ($urandom_range(0, 499) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      frame_start = 1'b0;
      load_angle = 1'b0;
      repeat (6) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
